// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: op codes, FSM states and HI/LO bus width
// shared by the multiply/divide unit and the HI/LO file.
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

package hilo_muldiv_pkg;

  localparam int DATA_BUS_W = $bits(logic [`DATA_BUS]);

  localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'd2;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_MADD  = 3'd4;
  localparam logic [2:0] MULDIV_OP_MADDU = 3'd5;
  localparam logic [2:0] MULDIV_OP_MSUB  = 3'd6;
  localparam logic [2:0] MULDIV_OP_MSUBU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DONE    = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(
    input logic [2:0] op
  );
    return (op == MULDIV_OP_DIV) ||
           (op == MULDIV_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(
    input logic [2:0] op
  );
    return (op == MULDIV_OP_MULT) ||
           (op == MULDIV_OP_DIV)  ||
           (op == MULDIV_OP_MADD) ||
           (op == MULDIV_OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_div_core.sv
// hilo_div_core: iterative radix-2 restoring divider on operand
// magnitudes, one quotient bit per cycle, signs fixed on output.
// Ports: clk, rst, clear (abort), start (load operands), dividend,
// divisor, is_signed -> done (last iteration), quotient, remainder.
module hilo_div_core
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              is_signed,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  logic              active_q, active_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              sa, sb;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    sa       = is_signed & dividend[DATA_W-1];
    sb       = is_signed & divisor[DATA_W-1];
    shifted  = {rem_q, quo_q[DATA_W-1]};
    trial    = shifted - {1'b0, dvs_q};
    if (clear) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = sa ? -dividend : dividend;
      dvs_d    = sb ? -divisor : divisor;
      negq_d   = sa ^ sb;
      negr_d   = sa;
    end else if (active_q) begin
      // A borrow out of the trial subtract means restore.
      rem_d = trial[DATA_W] ? shifted[DATA_W-1:0]
                            : trial[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
      if (cnt_q == LAST) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  assign done      = active_q & (cnt_q == LAST);
  assign quotient  = negq_q ? -quo_q : quo_q;
  assign remainder = negr_q ? -rem_q : rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle EX-stage mul/div producing HI/LO write
// data + strobe, stalling the pipe while an op is in flight.
// Ports: clk, rst (sync, high), start, op, operand_1/2,
// hi/lo_input_data (forwarded HI/LO), flush -> stall_request,
// hilo_write_en, hi/lo_write_data, busy.
// Macro HILO_MULDIV_ACCUM_EN enables MADD/MADDU/MSUB/MSUBU.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  input  logic [DATA_W-1:0] hi_input_data,
  input  logic [DATA_W-1:0] lo_input_data,
  input  logic              flush,
  output logic              stall_request,
  output logic              hilo_write_en,
  output logic [DATA_W-1:0] hi_write_data,
  output logic [DATA_W-1:0] lo_write_data,
  output logic              busy
);

  localparam int PW = 2 * DATA_W;

  muldiv_state_e     state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              dz_q, dz_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              op_mul;
  logic              op_ok;
  logic              div_start;
  logic              div_done;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic              msgn;
  logic [PW-1:0]     ext_a, ext_b;
  logic [PW-1:0]     res;

  always_comb begin
    op_mul = 1'b0;
    case (op)
      MULDIV_OP_MULT,
      MULDIV_OP_MULTU: op_mul = 1'b1;
`ifdef HILO_MULDIV_ACCUM_EN
      MULDIV_OP_MADD,
      MULDIV_OP_MADDU,
      MULDIV_OP_MSUB,
      MULDIV_OP_MSUBU: op_mul = 1'b1;
`endif
      default: op_mul = 1'b0;
    endcase
    op_ok = op_mul | op_is_div(op);
  end

  always_comb begin
    msgn  = op_is_signed(op_q);
    ext_a = {{DATA_W{msgn & a_q[DATA_W-1]}}, a_q};
    ext_b = {{DATA_W{msgn & b_q[DATA_W-1]}}, b_q};
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    dz_d          = dz_q;
    prod_d        = prod_q;
    div_start     = 1'b0;
    stall_request = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_request = start & op_ok;
        if (start & op_ok & ~flush) begin
          op_d = op;
          a_d  = operand_1;
          b_d  = operand_2;
          dz_d = op_is_div(op) & (operand_2 == '0);
          if (op_mul) begin
            state_d = ST_MUL;
          end else if (operand_2 == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_DIV_RUN;
            div_start = 1'b1;
          end
        end
      end
      ST_MUL: begin
        stall_request = 1'b1;
        prod_d        = ext_a * ext_b;
        state_d       = ST_DONE;
      end
      ST_DIV_RUN: begin
        stall_request = 1'b1;
        if (div_done) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  hilo_div_core #(
    .DATA_W     (DATA_W),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .start     (div_start),
    .dividend  (operand_1),
    .divisor   (operand_2),
    .is_signed (op == MULDIV_OP_DIV),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  // Accumulate reads the forwarded HI/LO in the write cycle
  // itself so a just-retired HI/LO write is seen.
  always_comb begin
    res = prod_q;
    if (op_is_div(op_q)) begin
      res = dz_q ? {a_q, {DATA_W{1'b1}}} : {rem, quo};
    end
`ifdef HILO_MULDIV_ACCUM_EN
    else if (op_q[2]) begin
      res = op_q[1]
          ? {hi_input_data, lo_input_data} - prod_q
          : {hi_input_data, lo_input_data} + prod_q;
    end
`endif
  end

`ifndef HILO_MULDIV_ACCUM_EN
  logic unused_hilo_in;
  assign unused_hilo_in = ^{hi_input_data, lo_input_data};
`endif

  assign hilo_write_en = (state_q == ST_DONE) & ~flush;
  assign busy          = (state_q != ST_IDLE);
  assign hi_d          = hilo_write_en ? res[PW-1:DATA_W] : hi_q;
  assign lo_d          = hilo_write_en ? res[DATA_W-1:0] : lo_q;
  assign hi_write_data = hi_d;
  assign lo_write_data = lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dz_q    <= 1'b0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dz_q    <= dz_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
